steak_drawer: RTL and testbench

//   Downstream of the steak doneness controller: consumes its colour_muscle/colour_fat pair and renders the steak into the VGA adapter.
//   - Sweeps a fixed rectangle one pixel per clock, row-major.
//   - Interior pixels get the muscle colour; a border RIM pixels thick gets the fat colour.
//   - Redraws automatically whenever either input colour changes.

---
 rtl/steak_drawer.sv | 147 ++++++++++++++
 tb/tb_steak_drawer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/steak_drawer.sv
// steak_drawer: sweeps the steak rectangle one pixel per clock, fat rim and muscle interior (STEAK_GRILL_MARKS_EN adds char diagonals).
// Latency: colour change seen at edge N -> LOAD after N+1 -> first plot after N+2; WIDTH*HEIGHT plot cycles per frame.
// Backpressure: none; colour changes during a frame collapse into a single follow-up frame.
module steak_drawer #(
    parameter logic [7:0] X0     = 8'd40,
    parameter logic [6:0] Y0     = 7'd30,
    parameter logic [7:0] WIDTH  = 8'd64,
    parameter logic [6:0] HEIGHT = 7'd48,
    parameter logic [2:0] RIM    = 3'd3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] colour_muscle,
    input  logic [8:0] colour_fat,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [8:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] RIM_X  = {5'd0, RIM};
    localparam logic [6:0] RIM_Y  = {4'd0, RIM};
    localparam logic [7:0] X_HI   = WIDTH - RIM_X;
    localparam logic [6:0] Y_HI   = HEIGHT - RIM_Y;
    localparam logic [7:0] X_LAST = WIDTH - 8'd1;
    localparam logic [6:0] Y_LAST = HEIGHT - 7'd1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t     state, state_nxt;
    logic [8:0] prev_m, prev_f, snap_m, snap_f;
    logic       pending, changed, load;
    logic [7:0] px, px_nxt;
    logic [6:0] py, py_nxt;
    logic       plot_nxt, done_nxt, on_rim;
    logic [8:0] colour_nxt;

    // No reset on the previous-value registers: they keep tracking the inputs
    // while resetn is low, so releasing reset does not look like a colour change.
    always_ff @(posedge clk) begin
        prev_m <= colour_muscle;
        prev_f <= colour_fat;
    end

    assign changed = (colour_muscle != prev_m) || (colour_fat != prev_f);

    always_comb begin
        state_nxt = state;
        px_nxt    = px;
        py_nxt    = py;
        plot_nxt  = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nxt = LOAD;
                    load      = 1'b1;
                    px_nxt    = 8'd0;
                    py_nxt    = 7'd0;
                end
            end
            LOAD: begin
                state_nxt = DRAW;
                plot_nxt  = 1'b1;
            end
            DRAW: begin
                if (px == X_LAST && py == Y_LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    plot_nxt = 1'b1;
                    if (px == X_LAST) begin
                        px_nxt = 8'd0;
                        py_nxt = py + 7'd1;
                    end else begin
                        px_nxt = px + 8'd1;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Colour is computed for the pixel about to be presented, not the current one.
    assign on_rim = (px_nxt < RIM_X) || (px_nxt >= X_HI) ||
                    (py_nxt < RIM_Y) || (py_nxt >= Y_HI);

`ifdef STEAK_GRILL_MARKS_EN
    logic [2:0] diag;
    assign diag = px_nxt[2:0] + py_nxt[2:0];

    always_comb begin
        colour_nxt = snap_m;
        if (on_rim)
            colour_nxt = snap_f;
        else if (diag == 3'd0)
            colour_nxt = 9'b001001001;
    end
`else
    always_comb begin
        colour_nxt = on_rim ? snap_f : snap_m;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            pending <= 1'b1;
            snap_m  <= 9'd0;
            snap_f  <= 9'd0;
            px      <= 8'd0;
            py      <= 7'd0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 9'd0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            px    <= px_nxt;
            py    <= py_nxt;
            if (load) begin
                snap_m <= colour_muscle;
                snap_f <= colour_fat;
            end
            // A change on the LOAD edge itself must survive the clear.
            if (changed)
                pending <= 1'b1;
            else if (load)
                pending <= 1'b0;
            plot <= plot_nxt;
            done <= done_nxt;
            busy <= (state_nxt != IDLE);
            if (plot_nxt) begin
                x      <= X0 + px_nxt;
                y      <= Y0 + py_nxt;
                colour <= colour_nxt;
            end
        end
    end

endmodule

// File: tb/tb_steak_drawer.sv
// Bench for steak_drawer: timeline reference model of frames plus directed pixel and timing checks.
module tb_steak_drawer;

    localparam int W = 64, H = 48, RIM = 3, X0 = 40, Y0 = 30;
    localparam int FRAME = W * H;

    logic       clk = 1'b0;
    logic       resetn;
    logic [8:0] muscle = 9'o700, fat = 9'o777;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] colour;
    logic       plot, busy, done;

    int n_vec = 0, n_err = 0;

    steak_drawer dut (
        .clk(clk), .resetn(resetn),
        .colour_muscle(muscle), .colour_fat(fat),
        .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pix_col(input int px, input int py,
                                           input logic [8:0] m, input logic [8:0] f);
        if (px < RIM || px >= W - RIM || py < RIM || py >= H - RIM) return f;
`ifdef STEAK_GRILL_MARKS_EN
        if ((px + py) % 8 == 0) return 9'o111;
`endif
        return m;
    endfunction

    // Reference: a frame is a timeline measured from its load edge.
    // age 0 load, 1..FRAME pixels, FRAME+1 done pulse, FRAME+2 back to idle.
    bit         m_active = 1'b0, m_pending = 1'b1, chg, loaded;
    int         m_age = 0, k;
    logic [8:0] m_prev_m, m_prev_f, s_m, s_f;
    logic       e_plot = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [7:0] e_x = 8'd0;
    logic [6:0] e_y = 7'd0;
    logic [8:0] e_c = 9'd0;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_active = 1'b0; m_pending = 1'b1; m_age = 0;
            e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_x = 8'd0; e_y = 7'd0; e_c = 9'd0;
            m_prev_m = muscle; m_prev_f = fat;
        end else begin
            chg = (muscle != m_prev_m) || (fat != m_prev_f);
            m_prev_m = muscle; m_prev_f = fat;
            loaded = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == FRAME + 2) m_active = 1'b0;
            end else if (m_pending) begin
                m_active = 1'b1; m_age = 0; s_m = muscle; s_f = fat; loaded = 1'b1;
            end
            m_pending = loaded ? chg : (m_pending | chg);
            e_plot = m_active && m_age >= 1 && m_age <= FRAME;
            e_done = m_active && m_age == FRAME + 1;
            e_busy = m_active;
            if (e_plot) begin
                k   = m_age - 1;
                e_x = 8'(X0 + k % W);
                e_y = 7'(Y0 + k / W);
                e_c = pix_col(k % W, k / W, s_m, s_f);
            end
        end
    end

    // Monitor: cycle compare against the model, plus a frame buffer of what was drawn.
    logic [8:0] fb [160][120];
    int         plot_run = 0, done_cnt = 0;
    logic [7:0] first_x;
    logic [6:0] first_y;
    logic [8:0] first_c;

    initial forever begin
        @(negedge clk);
        chk("out", {5'd0, plot, busy, done, x, y, colour},
                   {5'd0, e_plot, e_busy, e_done, e_x, e_y, e_c});
        if (!resetn) begin
            plot_run = 0;
        end else begin
            if (plot) begin
                if (plot_run == 0) begin
                    first_x = x; first_y = y; first_c = colour;
                end
                plot_run++;
                if (x < 8'd160 && y < 7'd120) fb[x][y] = colour;
            end
            if (done) begin
                done_cnt++;
                chk("frame_len", plot_run, FRAME);
                plot_run = 0;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((m_active || m_pending) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 1);
    endtask

    task automatic wait_run(input int pixels);
        int n = 0;
        while (plot_run < pixels && n < 10000) begin
            @(posedge clk);
            n++;
        end
        chk("run_timeout", 32'(n < 10000), 1);
    endtask

    int base, lat;

    initial begin
        // Reset with the first colour pair already present.
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {plot, busy, done, x, y, colour}, 0);
        resetn = 1'b1;
        base = done_cnt;
        wait_idle(8000);
        chk("first_frames", done_cnt - base, 1);
        chk("first_x", first_x, 40);
        chk("first_y", first_y, 30);
        chk("first_c", first_c, 9'o777);
        chk("rim_42_33", fb[42][33], 9'o777);
        chk("mus_43_33", fb[43][33], 9'o700);
        chk("rim_103_77", fb[103][77], 9'o777);
`ifdef STEAK_GRILL_MARKS_EN
        chk("char_100_74", fb[100][74], 9'o111);
        chk("char_44_34", fb[44][34], 9'o111);
        chk("mus_45_34", fb[45][34], 9'o700);
        chk("rim_40_38", fb[40][38], 9'o777);
`else
        chk("mus_100_74", fb[100][74], 9'o700);
`endif

        // Idle colour change: latency to first plot.
        base = done_cnt;
        @(posedge clk); #1 muscle = 9'o500;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 2) chk("load_busy", {plot, busy}, 2'b01);
        end while (!plot && lat < 10);
        chk("latency", lat, 3);
        wait_idle(8000);
        chk("redraw_frames", done_cnt - base, 1);
        chk("mus_61_50", fb[61][50], 9'o500);
        chk("mus_43_33b", fb[43][33], 9'o500);

        // Three changes mid-frame: old frame finishes, exactly one more follows.
        base = done_cnt;
        @(posedge clk); #1 fat = 9'o666;
        wait_run(1000);
        #1 muscle = 9'o123;
        @(posedge clk); #1 muscle = 9'o234;
        @(posedge clk); #1 fat = 9'o055;
        wait_idle(12000);
        chk("coalesce_frames", done_cnt - base, 2);
        chk("coal_fat", fb[40][30], 9'o055);
        chk("coal_mus", fb[61][50], 9'o234);

        // Reset mid-frame, then a complete fresh frame.
        @(posedge clk); #1 muscle = 9'o600;
        wait_run(500);
        #1 resetn = 1'b0;
        #1 chk("rst_mid_plot", {plot, busy}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        base = done_cnt;
        wait_idle(8000);
        chk("post_rst_frames", done_cnt - base, 1);
        chk("post_rst_x", first_x, 40);
        chk("post_rst_y", first_y, 30);
        chk("post_rst_mus", fb[61][50], 9'o600);

        // All-zero colours erase the steak.
        @(posedge clk); #1 muscle = 9'd0; fat = 9'd0;
        wait_idle(8000);
        chk("erase_rim", fb[40][30], 0);
        chk("erase_mus", fb[61][50], 0);

        // Random colour traffic against the reference model.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3500)) @(posedge clk);
            #1;
            case ($urandom_range(0, 2))
                0: muscle = 9'($urandom);
                1: fat    = 9'($urandom);
                default: begin muscle = 9'($urandom); fat = 9'($urandom); end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1 muscle = 9'($urandom);
            end
        end
        wait_idle(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
